// File: rtl/fta_bus_pkg.sv
// FTA bus command/response types shared by the I/O bridge masters and slaves,
// plus the I/O arbiter's state encoding and idle address constant.
package fta_bus_pkg;

  typedef logic [7:0] fta_tranid_t;

  typedef struct packed {
    logic         cyc;
    logic         stb;
    logic         we;
    logic [15:0]  sel;
    fta_tranid_t  tid;
    logic [31:0]  padr;
    logic [127:0] dat;
  } fta_cmd_request128_t;

  typedef struct packed {
    fta_tranid_t  tid;
    logic         stall;
    logic         ack;
    logic         err;
    logic         rty;
    logic [127:0] dat;
  } fta_cmd_response128_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_RESP,
    ST_COMPLETE
  } fta_ioarb_state_t;

  localparam logic [31:0] FTA_IDLE_PADR = 32'hFFFFFFFF;

endpackage

// File: rtl/fta_rr_pick.sv
// Rotate-priority picker: grants the first asserting requester at or after ptr.
module fta_rr_pick #(
  parameter int NREQ = 4,
  parameter int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] grant,
  output logic [IW-1:0]   grant_idx
);

  logic [IW-1:0] idx;

  // Scan from the farthest position back to ptr so the nearest hit wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    idx       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/fta_io_arbiter128.sv
// Round-robin arbiter sharing one 128-bit FTA slave port among NREQ masters,
// one transaction in flight, with a watchdog that turns a lost response into err.
module fta_io_arbiter128
  import fta_bus_pkg::*;
#(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic                                rst_i,
  input  logic                                clk_i,
  input  fta_cmd_request128_t  [NREQ-1:0]     s_req,
  output fta_cmd_response128_t [NREQ-1:0]     s_resp,
  output fta_cmd_request128_t                 m_req,
  input  fta_cmd_response128_t                m_resp,
  output logic                                busy_o
);

  localparam int IW = $clog2(NREQ);

  fta_ioarb_state_t     state, state_nxt;
  logic [IW-1:0]        rr_ptr, gidx, pick_idx;
  logic [NREQ-1:0]      req_cyc, pick_grant;
  fta_cmd_request128_t  lreq;
  fta_cmd_response128_t resp_q;
  logic [9:0]           wdog;
  logic                 match, tmo;

  always_comb begin
    req_cyc = '0;
    for (int i = 0; i < NREQ; i++) req_cyc[i] = s_req[i].cyc;
  end

  fta_rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .req       (req_cyc),
    .ptr       (rr_ptr),
    .grant     (pick_grant),
    .grant_idx (pick_idx)
  );

  assign match = (state == ST_WAIT_RESP) && (m_resp.ack || m_resp.err || m_resp.rty) &&
                 (m_resp.tid == lreq.tid);
  // Fires on the cycle the count would reach TIMEOUT; a real match still wins.
  assign tmo   = (state == ST_WAIT_RESP) && ((wdog + 10'd1) == 10'(TIMEOUT));

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:      if (|req_cyc) state_nxt = ST_ISSUE;
      ST_ISSUE:     state_nxt = ST_WAIT_RESP;
      ST_WAIT_RESP: if (match || tmo) state_nxt = ST_COMPLETE;
      ST_COMPLETE:  state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state  <= ST_IDLE;
      rr_ptr <= '0;
      gidx   <= '0;
      lreq   <= '0;
      resp_q <= '0;
      wdog   <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        ST_IDLE: if (|req_cyc) begin
          gidx <= pick_idx;
          lreq <= s_req[pick_idx];
        end
        ST_ISSUE: wdog <= '0;
        ST_WAIT_RESP: begin
          wdog <= wdog + 10'd1;
          if (match) resp_q <= m_resp;
          else if (tmo) begin
            resp_q     <= '0;
            resp_q.err <= 1'b1;
            resp_q.tid <= lreq.tid;
          end
        end
        // A retry keeps the pointer so the same master re-wins if still asking.
        ST_COMPLETE: if (!resp_q.rty)
          rr_ptr <= (int'(gidx) == NREQ - 1) ? '0 : gidx + 1'b1;
        default: ;
      endcase
    end
  end

  always_comb begin
    m_req      = '0;
    m_req.padr = FTA_IDLE_PADR;
    if (state == ST_ISSUE) begin
      m_req     = lreq;
      m_req.cyc = 1'b1;
      m_req.stb = 1'b1;
    end
  end

  always_comb begin
    s_resp = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (state == ST_COMPLETE && int'(gidx) == i) s_resp[i] = resp_q;
      s_resp[i].stall = s_resp[i].stall |
                        (req_cyc[i] && !(state == ST_IDLE && pick_grant[i]));
    end
  end

  assign busy_o = (state != ST_IDLE);

endmodule

// File: tb/tb_fta_io_arbiter128.sv
// Scoreboard bench for fta_io_arbiter128: a round-robin reference model plans
// each batch's grant order; a bridge model answers; a monitor checks outputs.
module tb_fta_io_arbiter128;
  import fta_bus_pkg::*;

  localparam int N   = 4;
  localparam int TMO = 1023;

  typedef enum int {K_ACK, K_ERR, K_RTY, K_TMO} kind_e;
  typedef struct { int idx; kind_e kind; } plan_t;
  typedef struct { int idx; fta_cmd_request128_t req; } expreq_t;
  typedef struct {
    int idx; logic ack; logic err; logic rty;
    logic [7:0] tid; logic [127:0] dat; int cyc;
  } expresp_t;

  logic clk_i = 1'b0;
  logic rst_i = 1'b1;
  fta_cmd_request128_t  [N-1:0] s_req;
  fta_cmd_response128_t [N-1:0] s_resp;
  fta_cmd_request128_t          m_req;
  fta_cmd_response128_t         m_resp;
  logic                         busy_o;

  fta_io_arbiter128 #(.NREQ(N), .TIMEOUT(TMO)) dut (
    .rst_i (rst_i), .clk_i (clk_i), .s_req (s_req), .s_resp (s_resp),
    .m_req (m_req), .m_resp (m_resp), .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int cyc_cnt = 0;
  always @(posedge clk_i) cyc_cnt <= cyc_cnt + 1;

  int total = 0, bad = 0;
  plan_t    plan_q[$];
  expreq_t  ereq_q[$];
  expresp_t eresp_q[$];
  kind_e    force_q[$];
  fta_cmd_request128_t cur_req [N];
  fta_cmd_request128_t idle_req;
  logic [N-1:0] active = '0;
  int  m_ptr = 0;
  int  owner = -1;
  bit  mon_en = 1'b1, br_en = 1'b1, dir_dat = 1'b0, force_stray = 1'b0;

  task automatic chk(input string nm, input logic [255:0] got, input logic [255:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Monitor: every m_req strobe and every s_resp pulse must match the scoreboard.
  bit prev_mcyc = 1'b0;
  expreq_t  er;
  expresp_t ep;
  always @(negedge clk_i) begin
    if (!rst_i && mon_en) begin
      if (m_req.cyc) begin
        if (prev_mcyc) begin
          total++; bad++;
          $display("FAIL mreq_one_cycle: got cyc high two cycles expected one");
        end else if (ereq_q.size() == 0) begin
          total++; bad++;
          $display("FAIL mreq_unexpected: got padr %0h expected no request", m_req.padr);
        end else begin
          er = ereq_q.pop_front();
          chk("mreq_fields", 256'(m_req), 256'(er.req));
          chk("busy_issue", 256'(busy_o), 256'(1'b1));
          owner = er.idx;
        end
      end else if (prev_mcyc) begin
        chk("mreq_idle", 256'(m_req), 256'(idle_req));
      end
      prev_mcyc = m_req.cyc;
      if (owner >= 0)
        for (int i = 0; i < N; i++)
          if (i != owner && s_req[i].cyc) chk("stall", 256'(s_resp[i].stall), 256'(1'b1));
      for (int i = 0; i < N; i++) begin
        if (s_resp[i].ack || s_resp[i].err || s_resp[i].rty) begin
          if (eresp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL resp_unexpected: got pulse on requester %0d tid %0h expected none",
                     i, s_resp[i].tid);
          end else begin
            ep = eresp_q.pop_front();
            chk("resp_idx", 256'(i), 256'(ep.idx));
            chk("resp_kind", 256'({s_resp[i].ack, s_resp[i].err, s_resp[i].rty}),
                256'({ep.ack, ep.err, ep.rty}));
            chk("resp_tid", 256'(s_resp[i].tid), 256'(ep.tid));
            chk("resp_dat", 256'(s_resp[i].dat), 256'(ep.dat));
            chk("resp_cycle", 256'(cyc_cnt), 256'(ep.cyc));
          end
          owner = -1;
        end
      end
    end else begin
      prev_mcyc = 1'b0;
    end
  end

  // Bridge model: answers each strobe according to the planned response kind.
  initial begin : bridge
    plan_t p;
    int c, d;
    logic [7:0] t;
    logic [127:0] dv;
    forever begin
      @(posedge clk_i); #2;
      if (br_en && !rst_i && m_req.cyc) begin
        c = cyc_cnt;
        if (plan_q.size() == 0) begin
          total++; bad++;
          $display("FAIL bridge_plan: got strobe for padr %0h expected none", m_req.padr);
        end else begin
          p = plan_q.pop_front();
          t = cur_req[p.idx].tid;
          if (p.kind == K_TMO) begin
            eresp_q.push_back('{p.idx, 1'b0, 1'b1, 1'b0, t, 128'd0, c + 1 + TMO});
          end else begin
            d = $urandom_range(1, 5);
            repeat (d) begin @(posedge clk_i); #2; end
            if (force_stray || $urandom_range(0, 2) == 0) begin
              m_resp = '0; m_resp.ack = 1'b1; m_resp.tid = t ^ 8'h80;
              m_resp.dat = {$urandom, $urandom, $urandom, $urandom};
              @(posedge clk_i); #2;
            end
            dv = dir_dat ? {4{32'h12345678}} : {$urandom, $urandom, $urandom, $urandom};
            m_resp = '0; m_resp.tid = t; m_resp.dat = dv;
            m_resp.ack = (p.kind == K_ACK);
            m_resp.err = (p.kind == K_ERR);
            m_resp.rty = (p.kind == K_RTY);
            eresp_q.push_back('{p.idx, m_resp.ack, m_resp.err, m_resp.rty, t, dv, cyc_cnt + 1});
            @(posedge clk_i); #2;
            m_resp = '0;
          end
        end
      end
    end
  end

  // Requesters hold cyc until ack or err; a retry leaves the request up.
  initial begin : drivers
    forever begin
      @(posedge clk_i); #2;
      for (int i = 0; i < N; i++)
        if (active[i] && (s_resp[i].ack || s_resp[i].err)) begin
          s_req[i]  = '0;
          active[i] = 1'b0;
        end
    end
  end

  task automatic run_batch(input logic [N-1:0] mask, input bit dir);
    logic [N-1:0] pend;
    int g, r, t;
    kind_e k;
    for (int i = 0; i < N; i++) begin
      cur_req[i] = '0;
      if (mask[i]) begin
        cur_req[i].cyc  = 1'b1;
        cur_req[i].stb  = 1'b1;
        cur_req[i].we   = 1'($urandom);
        cur_req[i].sel  = 16'($urandom);
        cur_req[i].tid  = 8'($urandom);
        cur_req[i].padr = $urandom;
        cur_req[i].dat  = {$urandom, $urandom, $urandom, $urandom};
      end
    end
    if (dir) begin
      cur_req[1].we   = 1'b0;
      cur_req[1].padr = 32'hFEE00010;
      cur_req[1].tid  = 8'h21;
    end
    // Reference: serve pending requesters round-robin from the model pointer.
    pend = mask;
    while (pend != '0) begin
      g = -1;
      for (int j = 0; j < N; j++)
        if (g < 0 && pend[(m_ptr + j) % N]) g = (m_ptr + j) % N;
      if (force_q.size() != 0) k = force_q.pop_front();
      else begin
        r = $urandom_range(0, 99);
        k = (r < 60) ? K_ACK : (r < 75) ? K_ERR : (r < 93) ? K_RTY : K_TMO;
      end
      plan_q.push_back('{g, k});
      ereq_q.push_back('{g, cur_req[g]});
      if (k != K_RTY) begin
        pend[g] = 1'b0;
        m_ptr   = (g + 1) % N;
      end
    end
    @(posedge clk_i); #2;
    for (int i = 0; i < N; i++) if (mask[i]) s_req[i] = cur_req[i];
    active = mask;
    t = 0;
    while (active != '0 && t < 20000) begin @(posedge clk_i); #3; t++; end
    if (active != '0) begin
      total++; bad++;
      $display("FAIL batch_timeout: got pending mask %b expected 0", active);
      active = '0; s_req = '0;
    end
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("idle_busy", 256'(busy_o), 256'(1'b0));
    for (int i = 0; i < N; i++) chk("idle_resp", 256'(s_resp[i]), 256'(0));
    chk("queues_drained", 256'(plan_q.size() + ereq_q.size() + eresp_q.size()), 256'(0));
  endtask

  initial begin : main
    int t;
    s_req = '0; m_resp = '0;
    idle_req = '0; idle_req.padr = FTA_IDLE_PADR;
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_mreq", 256'(m_req), 256'(idle_req));
    chk("rst_busy", 256'(busy_o), 256'(1'b0));
    for (int i = 0; i < N; i++) chk("rst_resp", 256'(s_resp[i]), 256'(0));
    @(posedge clk_i); #2; rst_i = 1'b0;

    force_q = '{K_ACK, K_ACK};
    run_batch(4'b0101, 1'b0);
    force_q = '{K_ACK};
    dir_dat = 1'b1;
    run_batch(4'b0010, 1'b1);
    dir_dat = 1'b0;
    force_q = '{K_ACK, K_ACK, K_ACK, K_ACK, K_ACK, K_ACK, K_ACK, K_ACK};
    run_batch(4'b1111, 1'b0);
    force_q = '{K_TMO};
    run_batch(4'b0001, 1'b0);
    force_q = '{K_RTY, K_RTY, K_ACK};
    force_stray = 1'b1;
    run_batch(4'b1000, 1'b0);
    force_stray = 1'b0;
    repeat (25) run_batch(4'($urandom_range(1, 15)), 1'b0);

    // Reset while waiting for a response, then a late ack that must be dropped.
    br_en = 1'b0; mon_en = 1'b0;
    cur_req[3] = '0; cur_req[3].cyc = 1'b1; cur_req[3].stb = 1'b1;
    cur_req[3].tid = 8'h5A; cur_req[3].padr = 32'hFEE00100;
    @(posedge clk_i); #2; s_req[3] = cur_req[3];
    t = 0;
    do begin @(negedge clk_i); t++; end while (!m_req.cyc && t < 10);
    chk("rst_test_issue", 256'(m_req.cyc), 256'(1'b1));
    repeat (3) @(posedge clk_i);
    #2; rst_i = 1'b1; s_req = '0;
    @(posedge clk_i); #2; rst_i = 1'b0;
    @(negedge clk_i);
    chk("midrst_mreq", 256'(m_req), 256'(idle_req));
    chk("midrst_busy", 256'(busy_o), 256'(1'b0));
    for (int i = 0; i < N; i++) chk("midrst_resp", 256'(s_resp[i]), 256'(0));
    @(posedge clk_i); #2;
    m_resp = '0; m_resp.ack = 1'b1; m_resp.tid = 8'h5A;
    @(posedge clk_i); #2; m_resp = '0;
    repeat (3) begin
      @(negedge clk_i);
      chk("late_ack_resp", 256'(s_resp[3]), 256'(0));
      chk("late_ack_busy", 256'(busy_o), 256'(1'b0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
